// File: rtl/jmp_fetch.sv
// Byte-serial fetch of a 3-byte 8080 jump (opcode, lo, hi) with opcode check.
// Define JMP_FETCH_COND_EN to also accept conditional jumps (11ccc010).
module jmp_fetch #(
    parameter int DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        rd,
    input  logic [7:0]  data_in,
    input  logic        src_valid,
    output logic        busy,
    output logic        done,
    output logic        jmp_ok,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  opcode,
    output logic [15:0] target,
    output logic        cond
);

`ifdef JMP_FETCH_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    localparam logic [3:0] LAT = 4'(DATA_LAT);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT, CHECK, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] idx;

    function automatic logic is_cond(input logic [7:0] op);
        return COND_EN && (op[7:6] == 2'b11) && (op[2:0] == 3'b010);
    endfunction

    function automatic logic op_ok(input logic [7:0] op);
        return (op == 8'hC3) || is_cond(op);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            rd       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            jmp_ok   <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            opcode   <= 8'h00;
            target   <= 16'h0000;
            cond     <= 1'b0;
        end else begin
            rd   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        jmp_ok   <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        cond     <= 1'b0;
                        idx      <= 2'd0;
                        busy     <= 1'b1;
                        if (src_valid) begin
                            state <= STROBE;
                            rd    <= 1'b1;
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                STROBE: begin
                    state <= WAIT;
                    cnt   <= LAT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        case (idx)
                            2'd0: begin
                                opcode <= data_in;
                                state  <= CHECK;
                            end
                            2'd1: begin
                                target[7:0] <= data_in;
                                idx         <= 2'd2;
                                // source availability is only sampled ahead of a strobe
                                if (src_valid) begin
                                    state <= STROBE;
                                    rd    <= 1'b1;
                                end else begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    err      <= 1'b1;
                                    err_code <= 2'b01;
                                end
                            end
                            default: begin
                                target[15:8] <= data_in;
                                state        <= DONE;
                                done         <= 1'b1;
                                jmp_ok       <= 1'b1;
                                cond         <= is_cond(opcode);
                            end
                        endcase
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (op_ok(opcode)) begin
                        idx <= 2'd1;
                        if (src_valid) begin
                            state <= STROBE;
                            rd    <= 1'b1;
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jmp_fetch.sv
// Directed bench for jmp_fetch: registered responders, DATA_LAT=1 and DATA_LAT=3 instances.
module tb_jmp_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start3, rsp_clr;
    logic rd, busy, done, jmp_ok, err, cond, src_valid;
    logic rd3, busy3, done3, jmp_ok3, err3, cond3, src_valid3;
    logic [1:0]  err_code, err_code3;
    logic [7:0]  opcode, opcode3, data_in, data_in3;
    logic [15:0] target, target3;

    logic [7:0] mem [0:2];
    int nbytes = 0;
    int ptr, ptr3;
    int errors = 0, checks = 0;
    int rel, done_at;
    int rd_log[$];

    jmp_fetch #(.DATA_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rd(rd), .data_in(data_in),
        .src_valid(src_valid), .busy(busy), .done(done), .jmp_ok(jmp_ok), .err(err),
        .err_code(err_code), .opcode(opcode), .target(target), .cond(cond));

    jmp_fetch #(.DATA_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .rd(rd3), .data_in(data_in3),
        .src_valid(src_valid3), .busy(busy3), .done(done3), .jmp_ok(jmp_ok3), .err(err3),
        .err_code(err_code3), .opcode(opcode3), .target(target3), .cond(cond3));

    // Registered responders: byte appears the cycle after the rd strobe.
    always @(posedge clk) begin
        if (reset || rsp_clr) begin
            ptr <= 0;
            if (reset) data_in <= 8'h00;
        end else if (rd) begin
            data_in <= (ptr < 3) ? mem[ptr] : 8'hEE;
            ptr     <= ptr + 1;
        end
    end
    always @(posedge clk) begin
        if (reset || rsp_clr) begin
            ptr3 <= 0;
            if (reset) data_in3 <= 8'h00;
        end else if (rd3) begin
            data_in3 <= (ptr3 < 3) ? mem[ptr3] : 8'hEE;
            ptr3     <= ptr3 + 1;
        end
    end
    assign src_valid  = ptr < nbytes;
    assign src_valid3 = ptr3 < nbytes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int n, input int e0, input int e1, input int e2);
        int exp_a[3];
        exp_a = '{e0, e1, e2};
        check({tag, "_rd_count"}, 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < n && i < 3; i++)
            check({tag, "_rd_cycle"}, 32'((i < rd_log.size()) ? rd_log[i] : -1), 32'(exp_a[i]));
    endtask

    // Start a fetch on one instance; rel counts cycles after the edge that samples start.
    task automatic go(input bit sel, input bit hold);
        logic r, d;
        rd_log.delete();
        done_at = -1;
        @(negedge clk) rsp_clr = 1'b1;
        @(negedge clk) begin
            rsp_clr = 1'b0;
            if (sel) start3 = 1'b1; else start = 1'b1;
        end
        rel = 0;
        while (done_at < 0 && rel < 40) begin
            @(negedge clk);
            rel++;
            start3 = 1'b0;
            start  = hold && !sel && rel >= 2 && rel <= 7;
            r = sel ? rd3 : rd;
            d = sel ? done3 : done;
            if (r) rd_log.push_back(rel);
            if (d) done_at = rel;
        end
        start = 1'b0;
        if (done_at < 0) begin
            checks++;
            errors++;
            $error("FAIL done_timeout observed=none expected=done within 40 cycles");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start3 = 1'b0; rsp_clr = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rd", 32'(rd), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_jmp_ok", 32'(jmp_ok), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_target", 32'(target), 0);
        check("rst_cond", 32'(cond), 0);
        reset = 1'b0;

        // Successful JMP FD00
        mem[0] = 8'hC3; mem[1] = 8'h00; mem[2] = 8'hFD; nbytes = 3;
        go(0, 0);
        chk_rd("ok", 3, 1, 4, 6);
        check("ok_done_at", 32'(done_at), 8);
        check("ok_jmp_ok", 32'(jmp_ok), 1);
        check("ok_err", 32'(err), 0);
        check("ok_err_code", 32'(err_code), 0);
        check("ok_target", 32'(target), 32'hFD00);
        check("ok_opcode", 32'(opcode), 32'hC3);
        check("ok_cond", 32'(cond), 0);
        @(negedge clk);
        check("ok_done_pulse", 32'(done), 0);
        check("ok_busy_after", 32'(busy), 0);
        check("ok_jmp_ok_hold", 32'(jmp_ok), 1);

        // Bad opcode (HLT)
        mem[0] = 8'h76; nbytes = 3;
        go(0, 0);
        chk_rd("bad", 1, 1, 0, 0);
        check("bad_done_at", 32'(done_at), 4);
        check("bad_err", 32'(err), 1);
        check("bad_err_code", 32'(err_code), 2);
        check("bad_jmp_ok", 32'(jmp_ok), 0);
        check("bad_target", 32'(target), 32'hFD00);
        check("bad_opcode", 32'(opcode), 32'h76);

        // Source exhausted after byte 1
        mem[0] = 8'hC3; mem[1] = 8'h34; nbytes = 2;
        go(0, 0);
        chk_rd("exh", 2, 1, 4, 0);
        check("exh_done_at", 32'(done_at), 6);
        check("exh_err_code", 32'(err_code), 1);
        check("exh_err", 32'(err), 1);
        check("exh_target", 32'(target), 32'hFD34);

        // Source empty at start
        nbytes = 0;
        go(0, 0);
        chk_rd("empty", 0, 0, 0, 0);
        check("empty_done_at", 32'(done_at), 1);
        check("empty_err_code", 32'(err_code), 1);
        check("empty_opcode", 32'(opcode), 32'hC3);

        // Reset in cycle 4
        mem[0] = 8'hC3; mem[1] = 8'h00; mem[2] = 8'hFD; nbytes = 3;
        @(negedge clk) rsp_clr = 1'b1;
        @(negedge clk) begin rsp_clr = 1'b0; start = 1'b1; end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_rd_cycle4", 32'(rd), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rd", 32'(rd), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_target", 32'(target), 0);
        check("mid_opcode", 32'(opcode), 0);
        reset = 1'b0;
        go(0, 0);
        chk_rd("rerun", 3, 1, 4, 6);
        check("rerun_done_at", 32'(done_at), 8);
        check("rerun_target", 32'(target), 32'hFD00);

        // start held during cycles 2..7 is ignored
        go(0, 1);
        chk_rd("hold", 3, 1, 4, 6);
        check("hold_done_at", 32'(done_at), 8);
        repeat (3) @(negedge clk);
        check("hold_busy_after", 32'(busy), 0);
        check("hold_rd_after", 32'(rd), 0);

        // DATA_LAT = 3
        go(1, 0);
        chk_rd("lat3", 3, 1, 6, 10);
        check("lat3_done_at", 32'(done_at), 14);
        check("lat3_jmp_ok", 32'(jmp_ok3), 1);
        check("lat3_target", 32'(target3), 32'hFD00);

        // Conditional jump JZ 1000
        mem[0] = 8'hCA; mem[1] = 8'h00; mem[2] = 8'h10; nbytes = 3;
        go(0, 0);
`ifdef JMP_FETCH_COND_EN
        chk_rd("cjmp", 3, 1, 4, 6);
        check("cjmp_jmp_ok", 32'(jmp_ok), 1);
        check("cjmp_cond", 32'(cond), 1);
        check("cjmp_target", 32'(target), 32'h1000);
`else
        chk_rd("cjmp", 1, 1, 0, 0);
        check("cjmp_err_code", 32'(err_code), 2);
        check("cjmp_cond", 32'(cond), 0);
        check("cjmp_target", 32'(target), 32'hFD00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jmp_fetch.md
# jmp_fetch

Bus-initiator that pulls a 3-byte 8080 jump instruction from a byte-serial read source (the post-reset jump vector source, or any responder with the same edge-triggered `rd` protocol). It issues `rd` strobes, captures opcode and little-endian address, checks the opcode, and reports the decoded target. It sits between the reset/boot controller and the vector source, and is used for boot-vector self-check and front-panel "examine entry point".

## Interface
- `DATA_LAT`, 1: cycles, with `rd` low, between the end of an `rd`-high cycle and the `data_in` sample edge; legal range 1..15.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a fetch; sampled only in IDLE.
- `rd` out 1: read strobe to source; one-cycle high pulse per byte.
- `data_in` in 8: byte from source.
- `src_valid` in 1: source still has bytes to give.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the fetch ends (success or error).
- `jmp_ok` out 1: last fetch decoded a valid jump.
- `err` out 1: last fetch failed.
- `err_code` out 2: 00 none, 01 source exhausted, 10 bad opcode.
- `opcode` out 8: captured byte 0.
- `target` out 16: {byte2, byte1}.
- `cond` out 1: captured opcode was conditional (only with the macro; otherwise tied 0).

## Operation
- States: IDLE, STROBE, WAIT, CHECK, DONE.
- IDLE:
  - `start`=1 clears `jmp_ok`, `err`, `err_code`, `cond` and sets byte index to 0.
  - If `src_valid`=0 it goes directly to DONE with err_code 01. Otherwise it goes to STROBE.
- STROBE: `rd`=1 for exactly one cycle, then WAIT with the counter loaded to `DATA_LAT`.
- WAIT:
  - `rd`=0 and the counter decrements.
  - On the last WAIT cycle's edge, `data_in` is captured into byte[index]. Index 0 goes to CHECK. Index 1 advances the index and re-enters STROBE if `src_valid`=1, else goes to DONE with err 01. Index 2 goes to DONE with `jmp_ok`=1.
- CHECK (one cycle):
  - Opcode 0xC3 increments the index and goes to STROBE, subject to the same `src_valid` gate.
  - Any other opcode goes to DONE with err_code 10. No further `rd` is issued.
- DONE: `done`=1 for one cycle, then IDLE.
- `src_valid` is checked only before each STROBE, never during WAIT.
- `opcode` and `target` update as bytes are captured. Bytes not fetched keep their previous values.
- `start` while busy is ignored.
- `rd` is never high on two consecutive cycles, because the source detects rising edges.

## Timing
- Reset values: `rd`=0, `busy`=0, `done`=0, `jmp_ok`=0, `err`=0, `err_code`=00, `opcode`=0x00, `target`=0x0000, `cond`=0. State is IDLE.
- Cycle 0 is the edge that samples `start`=1.
  - `rd` is high in cycle 1.
  - Byte 0 is captured at the edge ending cycle 1+`DATA_LAT`.
  - CHECK takes 1 cycle.
  - Each later byte takes 1+`DATA_LAT` cycles.
- Successful fetch with `DATA_LAT`=1: `rd` is high in cycles 1, 4 and 6, and `done` is high in cycle 8.
- `jmp_ok`/`err` become valid in the same cycle as `done` and hold until the next accepted `start`.
- Reset mid-fetch: at the next edge, all outputs return to reset values and `rd` drops. Partial capture is discarded.
- The source must present each byte within `DATA_LAT` cycles of seeing `rd`. A registered responder meets this with `DATA_LAT`=1.

## Configuration
- `JMP_FETCH_COND_EN` defined:
  - CHECK also accepts conditional jumps matching 11ccc010 (0xC2, 0xCA, 0xD2, 0xDA, 0xE2, 0xEA, 0xF2, 0xFA).
  - For these, `cond`=1 at `done` and `jmp_ok`=1 on completion. For 0xC3, `cond`=0.
- Not defined: only 0xC3 is accepted, and `cond` is constant 0.

## Test plan
- Registered responder returning C3,00,FD, `src_valid` high, `DATA_LAT`=1, start pulse -> `rd` high in cycles 1, 4, 6, `done` in cycle 8, `jmp_ok`=1, `target`=0xFD00, `opcode`=0xC3.
- Responder returning 0x76 first -> exactly one `rd` pulse, `done` with `err`=1, `err_code`=10, `target` unchanged.
- Responder drops `src_valid` after byte 1 (returns C3,34) -> two `rd` pulses, `err_code`=01, `target`[7:0]=0x34.
- Responder returning C3,00,FD, reset asserted in cycle 4 -> next edge `rd`=0, `busy`=0, `target`=0x0000. A new start then completes normally.
- Responder returning C3,00,FD, second `start` in cycles 2–7 -> ignored, only three `rd` pulses. Repeat with `DATA_LAT`=3 -> `rd` gaps of 3 low cycles, `done` in cycle 14.
- With `JMP_FETCH_COND_EN`, responder returning CA,00,10 -> `jmp_ok`=1, `cond`=1, `target`=0x1000. Without the macro, same stimulus -> `err_code`=10.
